mbist_err_capture: RTL and testbench
====================================

# mbist_err_capture

Error-capture front end for the MBIST repair path. It compares memory read data against expected data during a BIST run and records each distinct failing address once, up to the repair limit. It then delivers those addresses one at a time as single-cycle `Error`/`ErrorAddr` pulses to the address-repair block. It also checks that block's `Correct` acknowledge and reports a sticky BIST fail when repair capacity is exceeded or refused.

## Interface
- `BIST_RAD_WD_I`, default from `mbist_def.svh`: width of the failing row address.
- `BIST_DATA_WD`, default 32: width of read and expected data.
- `BIST_ERR_LIMIT`, default from `mbist_def.svh`: maximum number of distinct repairable addresses; legal range 1..15.
- `clk` input, 1 bit: the single clock; all logic is on its rising edge.
- `rst_n` input, 1 bit: reset, synchronous and active-low.
- `clear` input, 1 bit: synchronous flush of all state at the start of a BIST run.
- `rd_valid` input, 1 bit: qualifies `rd_addr`, `rd_data` and `exp_data` for one cycle.
- `rd_addr` input, `BIST_RAD_WD_I` bits: address of the read being checked.
- `rd_data` input, `BIST_DATA_WD` bits: data returned by the memory.
- `exp_data` input, `BIST_DATA_WD` bits: expected data from the BIST pattern generator.
- `Correct` input, 1 bit: acknowledge from the repair block, registered by that block on the `Error` edge.
- `Error` output, 1 bit: one-cycle pulse that requests repair of `ErrorAddr`.
- `ErrorAddr` output, `BIST_RAD_WD_I` bits: the address being reported; held stable while `Error`=1.
- `err_cnt` output, 4 bits: number of distinct failing addresses logged; saturates at `BIST_ERR_LIMIT`.
- `bist_fail` output, 1 bit: sticky flag for an unrepairable memory.
- `idle` output, 1 bit: high when nothing is pending in the pipeline, the FIFO or the state machine.

## Operation
- **Stage 1 (compare):**
  - Register `cmp_vld = rd_valid && (rd_data != exp_data)` together with `cmp_addr`.
- **Stage 2 (dedup and log), active when `cmp_vld`=1:**
  - Compare `cmp_addr` against the logged-address table, entries `0..err_cnt-1`.
  - On a hit, drop the error with no side effects.
  - On a miss with `err_cnt < BIST_ERR_LIMIT`:
    - write `table[err_cnt]`;
    - increment `err_cnt`;
    - push the address into the FIFO.
  - On a miss with `err_cnt == BIST_ERR_LIMIT`, set `bist_fail`.
- **FIFO:**
  - Depth `BIST_ERR_LIMIT`. It cannot overflow, because pushes are bounded by `err_cnt`.
  - Order is first in, first out, so addresses are reported in detection order.
- **Issue FSM (`IDLE`, `ISSUE`, `GAP`):**
  - `IDLE` → `ISSUE` when the FIFO is not empty. On this edge, pop the FIFO head into the `ErrorAddr` register.
  - `ISSUE`: `Error`=1 for exactly this cycle. Always go to `GAP`.
  - `GAP`: `Error`=0. Sample `Correct`; if `Correct`=0, set `bist_fail`. Then go to `IDLE`.
  - As a result, `Error` pulses are at least 3 cycles apart.
- **`idle` output:** `idle = !cmp_vld && fifo_empty && state==IDLE`.
- **`clear`:**
  - Returns the FSM to `IDLE` and empties the FIFO.
  - Zeroes `err_cnt`, `bist_fail` and `cmp_vld`.
  - Table contents become don't-care.
  - `clear` takes priority over a `rd_valid` in the same cycle, and that read is discarded.
- **`clear` while in `ISSUE` or `GAP`:** abort the pulse. No `Correct` check is made.
- **Same address failing on consecutive cycles:** the second compare sees the table already updated, so it is dropped.

## Timing
- **Reset values:** `Error`=0, `ErrorAddr`=0, `err_cnt`=0, `bist_fail`=0, `idle`=1. The FSM is in `IDLE` and the FIFO is empty.
- **Latency:** a mismatch sampled at edge N gives `cmp_vld` in cycle N+1, the FIFO write at edge N+2, and `Error`=1 in cycle N+3. Minimum latency is 3 cycles.
- **`Correct` check:** `Correct` is evaluated during `GAP` (cycle N+4); `bist_fail` rises in cycle N+5.
- **Overflow case:** the miss that finds the table full sets `bist_fail` one edge after its stage-2 cycle.
- **Throughput:** one read per cycle. Back-to-back distinct errors queue in the FIFO and drain at one pulse per 3 cycles.
- **Outputs:** all outputs are registered except `idle`, which is combinational from registered state.

## Structure
- Shared package `mbist_def.svh`:
  - `BIST_RAD_WD_I`, `BIST_ERR_LIMIT`, `BIST_DATA_WD`;
  - the FSM state typedef `err_cap_st_t` {`IDLE`, `ISSUE`, `GAP`}.
- One sub-module, `mbist_err_fifo`:
  - synchronous FIFO, parameterised on width and depth;
  - `push`, `pop`, `empty`, `full` and `clear` ports.
- The logged-address table and the dedup compare stay in the top module.

## Test plan
- **Single error:** mismatch at `rd_addr`=0x12 → `Error` pulses once in cycle N+3 with `ErrorAddr`=0x12 and `err_cnt`=1. With `Correct`=1, `bist_fail` stays 0 and `idle` returns to 1.
- **Repeated address:** 0x12 fails on 3 consecutive cycles, then once more 20 cycles later → exactly one `Error` pulse and `err_cnt`=1.
- **Burst:** distinct addresses 0x01, 0x02, 0x03 fail back-to-back → three pulses in that order, 3 cycles apart, and `err_cnt`=3.
- **Capacity:** with `BIST_ERR_LIMIT`=4, 5 distinct failing addresses → 4 pulses and `err_cnt`=4. `bist_fail` is set one edge after the 5th miss; no 5th pulse.
- **Refused repair:** `Correct` held at 0 during `GAP` → `bist_fail`=1 in the following cycle.
- **Flush:** `clear` asserted in `ISSUE` together with `rd_valid` mismatching → `Error` drops, the FIFO empties, `err_cnt`=0 and `bist_fail`=0. No pulse occurs for the discarded read.

Source files
------------

// File: rtl/mbist_err_capture_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mbist_err_capture_pkg : shared widths, limits and issue-FSM states |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package mbist_err_capture_pkg;

   localparam int c_bist_rad_wd_i  = 8;
   localparam int c_bist_data_wd   = 32;
   localparam int c_bist_err_limit = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      GAP   = 2'd2
   } err_cap_st_t;

endpackage
`default_nettype wire

// File: rtl/mbist_err_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mbist_err_fifo : synchronous FIFO with flush, any depth >= 1       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mbist_err_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             empty,
   output logic             full
);

   localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_cnt_w = $clog2(DEPTH + 1);
   localparam logic [c_ptr_w-1:0] c_last = c_ptr_w'(DEPTH - 1);

   logic [WIDTH-1:0]   r_mem [2**c_ptr_w];
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_cnt_w-1:0] r_cnt;
   logic               w_push_ok;
   logic               w_pop_ok;

   assign empty     = (r_cnt == '0);
   assign full      = (r_cnt == c_cnt_w'(DEPTH));
   assign w_push_ok = push && !full;
   assign w_pop_ok  = pop && !empty;
   assign pop_data  = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push_ok)
         r_mem[r_wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_push_ok)
            r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;
         if (w_pop_ok)
            r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + 1'b1;
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/mbist_err_capture.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mbist_err_capture : dedups BIST read failures and issues them as   |
// | single-cycle Error/ErrorAddr repair requests. Revision: 1.0        |
// +--------------------------------------------------------------------+
module mbist_err_capture
   import mbist_err_capture_pkg::*;
#(
   parameter int BIST_RAD_WD_I  = c_bist_rad_wd_i,
   parameter int BIST_DATA_WD   = c_bist_data_wd,
   parameter int BIST_ERR_LIMIT = c_bist_err_limit
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     rd_valid,
   input  logic [BIST_RAD_WD_I-1:0] rd_addr,
   input  logic [BIST_DATA_WD-1:0]  rd_data,
   input  logic [BIST_DATA_WD-1:0]  exp_data,
   input  logic                     Correct,
   output logic                     Error,
   output logic [BIST_RAD_WD_I-1:0] ErrorAddr,
   output logic [3:0]               err_cnt,
   output logic                     bist_fail,
   output logic                     idle
);

   localparam int c_idx_w = (BIST_ERR_LIMIT > 1) ? $clog2(BIST_ERR_LIMIT) : 1;

   logic                      r_cmp_vld;
   logic [BIST_RAD_WD_I-1:0]  r_cmp_addr;
   logic [BIST_RAD_WD_I-1:0]  r_tab [2**c_idx_w];
   logic [3:0]                r_err_cnt;
   err_cap_st_t               r_state;
   logic                      r_error;
   logic [BIST_RAD_WD_I-1:0]  r_error_addr;
   logic                      r_bist_fail;

   logic [BIST_ERR_LIMIT-1:0] w_hit_vec;
   logic                      w_hit;
   logic                      w_tab_full;
   logic                      w_log;
   logic                      w_overflow;
   logic                      w_pop;
   logic                      w_fifo_empty;
   logic                      w_fifo_full;
   logic [BIST_RAD_WD_I-1:0]  w_fifo_head;

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         r_cmp_vld  <= 1'b0;
         r_cmp_addr <= '0;
      end else begin
         r_cmp_vld  <= rd_valid && (rd_data != exp_data);
         r_cmp_addr <= rd_addr;
      end
   end

   // Only entries below err_cnt are live; stale entries after clear never match.
   for (genvar i = 0; i < BIST_ERR_LIMIT; i++) begin : g_hit
      assign w_hit_vec[i] = (4'(i) < r_err_cnt) && (r_tab[i] == r_cmp_addr);
   end

   assign w_hit      = |w_hit_vec;
   assign w_tab_full = (r_err_cnt == 4'(BIST_ERR_LIMIT));
   assign w_log      = r_cmp_vld && !w_hit && !w_tab_full && !w_fifo_full;
   assign w_overflow = r_cmp_vld && !w_hit && w_tab_full;

   always_ff @(posedge clk) begin
      if (w_log && !clear)
         r_tab[r_err_cnt[c_idx_w-1:0]] <= r_cmp_addr;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear)
         r_err_cnt <= 4'd0;
      else if (w_log)
         r_err_cnt <= r_err_cnt + 4'd1;
   end

   mbist_err_fifo #(
      .WIDTH (BIST_RAD_WD_I),
      .DEPTH (BIST_ERR_LIMIT)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .push      (w_log),
      .push_data (r_cmp_addr),
      .pop       (w_pop),
      .pop_data  (w_fifo_head),
      .empty     (w_fifo_empty),
      .full      (w_fifo_full)
   );

   assign w_pop = (r_state == IDLE) && !w_fifo_empty && !clear;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_error      <= 1'b0;
         r_error_addr <= '0;
         r_bist_fail  <= 1'b0;
      end else if (clear) begin
         r_state     <= IDLE;
         r_error     <= 1'b0;
         r_bist_fail <= 1'b0;
      end else begin
         if (w_overflow)
            r_bist_fail <= 1'b1;
         case (r_state)
            IDLE: begin
               r_error <= 1'b0;
               if (!w_fifo_empty) begin
                  r_state      <= ISSUE;
                  r_error      <= 1'b1;
                  r_error_addr <= w_fifo_head;
               end
            end
            ISSUE: begin
               r_error <= 1'b0;
               r_state <= GAP;
            end
            GAP: begin
               // Correct was captured by the repair block on the Error edge.
               if (!Correct)
                  r_bist_fail <= 1'b1;
               r_state <= IDLE;
            end
            default: begin
               r_error <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign Error     = r_error;
   assign ErrorAddr = r_error_addr;
   assign err_cnt   = r_err_cnt;
   assign bist_fail = r_bist_fail;
   assign idle      = !r_cmp_vld && w_fifo_empty && (r_state == IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mbist_err_capture.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mbist_err_capture : directed + random bench with queue model    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_mbist_err_capture;

   localparam int RAD = 8;
   localparam int DW  = 32;
   localparam int LIM = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           clear = 1'b0;
   logic           rd_valid = 1'b0;
   logic [RAD-1:0] rd_addr = '0;
   logic [DW-1:0]  rd_data = '0;
   logic [DW-1:0]  exp_data = '0;
   logic           Correct = 1'b1;
   logic           Error;
   logic [RAD-1:0] ErrorAddr;
   logic [3:0]     err_cnt;
   logic           bist_fail;
   logic           idle;

   mbist_err_capture #(
      .BIST_RAD_WD_I  (RAD),
      .BIST_DATA_WD   (DW),
      .BIST_ERR_LIMIT (LIM)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .rd_valid  (rd_valid),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .exp_data  (exp_data),
      .Correct   (Correct),
      .Error     (Error),
      .ErrorAddr (ErrorAddr),
      .err_cnt   (err_cnt),
      .bist_fail (bist_fail),
      .idle      (idle)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int last_pulse = -100;
   int n_pulses = 0;

   // Reference model: list of logged addresses, expected pulse order, fail flag.
   logic [RAD-1:0] m_log[$];
   logic [RAD-1:0] m_pend[$];
   logic           m_fail = 1'b0;

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_read(input logic [RAD-1:0] a);
      bit seen = 0;
      foreach (m_log[i]) if (m_log[i] == a) seen = 1;
      if (!seen) begin
         if (m_log.size() < LIM) begin
            m_log.push_back(a);
            m_pend.push_back(a);
         end else begin
            m_fail = 1'b1;
         end
      end
   endtask

   task automatic model_clear();
      m_log.delete();
      m_pend.delete();
      m_fail = 1'b0;
   endtask

   // Drive one read for a single cycle; mismatch selects a corrupted rd_data.
   task automatic do_read(input logic [RAD-1:0] a, input bit mismatch);
      logic [DW-1:0] d;
      d        = $urandom;
      rd_valid = 1'b1;
      rd_addr  = a;
      exp_data = d;
      rd_data  = mismatch ? (d ^ (32'h1 << $urandom_range(31, 0))) : d;
      if (mismatch) model_read(a);
      tick();
      rd_valid = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      model_clear();
      last_pulse = -100;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      tick(); tick();
      while (!(idle && m_pend.size() == 0) && n < 300) begin
         tick();
         n++;
      end
      check({tag, "_drain_timeout"}, 32'(n < 300), 32'd1);
      repeat (3) tick();
      check({tag, "_err_cnt"}, 32'(err_cnt), 32'(m_log.size()));
      check({tag, "_bist_fail"}, 32'(bist_fail), 32'(m_fail));
      check({tag, "_pending"}, 32'(m_pend.size()), 32'd0);
      check({tag, "_idle"}, 32'(idle), 32'd1);
   endtask

   // Pulse monitor: every pulse must be the oldest unreported address, >=3 cycles apart.
   always @(negedge clk) begin
      if (rst_n && Error) begin
         n_pulses++;
         check("pulse_expected", 32'(m_pend.size() > 0), 32'd1);
         if (m_pend.size() > 0) begin
            check("pulse_addr", 32'(ErrorAddr), 32'(m_pend[0]));
            void'(m_pend.pop_front());
         end
         check("pulse_spacing", 32'(cyc - last_pulse >= 3), 32'd1);
         last_pulse = cyc;
         if (!Correct) m_fail = 1'b1;
      end
   end

   initial begin
      int p0;
      repeat (3) tick();
      check("rst_Error", 32'(Error), 32'd0);
      check("rst_ErrorAddr", 32'(ErrorAddr), 32'd0);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
      check("rst_bist_fail", 32'(bist_fail), 32'd0);
      check("rst_idle", 32'(idle), 32'd1);
      rst_n = 1'b1;
      tick();

      // Single error with exact latency
      do_read(8'h12, 1);
      check("single_c1_err", 32'(Error), 32'd0);
      tick();
      check("single_c2_err", 32'(Error), 32'd0);
      tick();
      check("single_c3_err", 32'(Error), 32'd1);
      check("single_addr", 32'(ErrorAddr), 32'h12);
      check("single_cnt", 32'(err_cnt), 32'd1);
      tick();
      check("single_c4_err", 32'(Error), 32'd0);
      drain("single");

      // Repeated address, including a late repeat
      do_clear();
      p0 = n_pulses;
      repeat (3) do_read(8'h12, 1);
      repeat (20) tick();
      do_read(8'h12, 1);
      drain("repeat");
      check("repeat_pulses", 32'(n_pulses - p0), 32'd1);

      // Burst of distinct addresses
      do_clear();
      p0 = n_pulses;
      do_read(8'h01, 1);
      do_read(8'h02, 1);
      do_read(8'h03, 1);
      drain("burst");
      check("burst_pulses", 32'(n_pulses - p0), 32'd3);

      // Capacity overflow: fail one edge after the 5th miss's stage-2 cycle
      do_clear();
      p0 = n_pulses;
      for (int i = 0; i < 5; i++) do_read(8'h20 + 8'(i), 1);
      check("cap_fail_stage2", 32'(bist_fail), 32'd0);
      tick();
      check("cap_fail_set", 32'(bist_fail), 32'd1);
      drain("cap");
      check("cap_pulses", 32'(n_pulses - p0), 32'd4);

      // Refused repair
      do_clear();
      Correct = 1'b0;
      do_read(8'h5a, 1);
      tick(); tick();
      check("refuse_issue", 32'(Error), 32'd1);
      tick();
      check("refuse_gap_fail", 32'(bist_fail), 32'd0);
      tick();
      check("refuse_fail", 32'(bist_fail), 32'd1);
      Correct = 1'b1;
      drain("refuse");

      // Flush during ISSUE with a mismatching read in the same cycle
      do_clear();
      do_read(8'h33, 1);
      do_read(8'h34, 1);
      tick();
      check("flush_issue", 32'(Error), 32'd1);
      clear    = 1'b1;
      rd_valid = 1'b1;
      rd_addr  = 8'h44;
      exp_data = 32'h0;
      rd_data  = 32'hffff_ffff;
      tick();
      clear    = 1'b0;
      rd_valid = 1'b0;
      model_clear();
      check("flush_error", 32'(Error), 32'd0);
      check("flush_cnt", 32'(err_cnt), 32'd0);
      check("flush_fail", 32'(bist_fail), 32'd0);
      p0 = n_pulses;
      repeat (10) tick();
      check("flush_no_pulse", 32'(n_pulses - p0), 32'd0);
      check("flush_idle", 32'(idle), 32'd1);

      // Randomized traffic against the model
      for (int r = 0; r < 4; r++) begin
         do_clear();
         for (int k = 0; k < 60; k++) begin
            if ($urandom_range(3, 0) == 0) tick();
            else do_read(8'($urandom_range(9, 0)) + 8'h80, $urandom_range(2, 0) == 0);
         end
         drain("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
